// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan sequencer for a 4-digit multiplexed seven-segment display with a double-buffered word.
// Optional build macro LZ_BLANK_EN enables leading-zero suppression on digits 1..3.
module seg_scan_ctrl #(
    parameter int DIGIT_CYC = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pl,
    input  logic        en,
    input  logic [15:0] din,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic [1:0]  scan_idx,
    output logic        ld_ack,
    output logic        frame_done
);

    localparam int CNT_MAX = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYC - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pend_q, pend_d;
    logic [3:0]    nib_q, nib_d;
    logic [3:0]    an_q, an_d;
    logic          ld_ack_q, ld_ack_d;
    logic          frame_done_q, frame_done_d;
    logic          lit_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        ld_ack_d     = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (en) begin
                    state_d = ST_BLANK;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_d = ST_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == DIGIT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    // Frame boundary: the only point where a pending word may become visible.
                    if (idx_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        if (pend_q) begin
                            disp_d   = shadow_q;
                            pend_d   = 1'b0;
                            ld_ack_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        // A load overrides the commit's pending clear, so a word captured on the commit edge waits a frame.
        if (pl) begin
            shadow_d = din;
            if (state_q == ST_OFF) begin
                disp_d   = din;
                pend_d   = 1'b0;
                ld_ack_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef LZ_BLANK_EN
        lit_d = (idx_d == 2'd0) || ((disp_d >> {idx_d, 2'b00}) != 16'd0);
`else
        lit_d = 1'b1;
`endif
        nib_d = 4'd0;
        an_d  = 4'd0;
        if (state_d != ST_OFF) begin
            nib_d = disp_d[{idx_d, 2'b00} +: 4];
        end
        if ((state_d == ST_SHOW) && lit_d) begin
            an_d = 4'b0001 << idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'd0;
            shadow_q     <= 16'd0;
            pend_q       <= 1'b0;
            nib_q        <= 4'd0;
            an_q         <= 4'd0;
            ld_ack_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            nib_q        <= nib_d;
            an_q         <= an_d;
            ld_ack_q     <= ld_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nib        = nib_q;
    assign an         = an_q;
    assign scan_idx   = idx_q;
    assign ld_ack     = ld_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: lit digits are scoreboarded, frame timing and load handshakes are checked.
// Expectations follow LZ_BLANK_EN when the bench is built with it defined.
module tb_seg_scan_ctrl;

   localparam int DIGIT_CYC = 4;
   localparam int BLANK_CYC = 1;
   localparam int FRAME     = 4 * (BLANK_CYC + DIGIT_CYC);

   logic        clk;
   logic        rst_n;
   logic        pl;
   logic        en;
   logic [15:0] din;
   logic [3:0]  nib;
   logic [3:0]  an;
   logic [1:0]  scan_idx;
   logic        ld_ack;
   logic        frame_done;

   int checks;
   int failures;
   int cyc;
   int litLen;
   int lastFd;
   int fdCount;
   int ackCount;
   int ackBase;
   int fdBase;
   bit lenCheck;
   bit fdCheck;
   logic [3:0] prevAn;
   logic [7:0] sbQ[$];
   logic [7:0] expEnt;

   seg_scan_ctrl #(
      .DIGIT_CYC(DIGIT_CYC),
      .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pl(pl),
      .en(en),
      .din(din),
      .nib(nib),
      .an(an),
      .scan_idx(scan_idx),
      .ld_ack(ld_ack),
      .frame_done(frame_done)
   );

   // Free-running clock and cycle counter used to time frame_done spacing
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports a mismatch
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, act, expv);
      end
   endtask

   // Push expected {an,nib} entries for the first n digit slots of a frame showing word w
   task automatic pushDigits(input logic [15:0] w, input int n);
      logic [15:0] rest;
      logic [3:0]  onehot;
      bit          lit;
      for (int k = 0; k < n; k++) begin
         rest   = w >> (4 * k);
         onehot = 4'b0001 << k;
`ifdef LZ_BLANK_EN
         lit = (k == 0) || (rest != 16'd0);
`else
         lit = 1'b1;
`endif
         if (lit) sbQ.push_back({onehot, rest[3:0]});
      end
   endtask

   task automatic pushFrame(input logic [15:0] w);
      pushDigits(w, 4);
   endtask

   // Drive one cycle of parallel load, starting just after the next rising edge
   task automatic applyStimulus(input logic [15:0] word);
      @(posedge clk); #1;
      pl  = 1'b1;
      din = word;
      @(posedge clk); #1;
      pl  = 1'b0;
   endtask

   task automatic waitShow(input logic [1:0] idx, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((an != 4'd0) && (scan_idx == idx)) begin
            hit = 1'b1;
            break;
         end
      end
      checkOutput(tag, {31'd0, hit}, 32'd1);
   endtask

   task automatic waitFrameDone(input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_done) begin
            hit = 1'b1;
            break;
         end
      end
      checkOutput(tag, {31'd0, hit}, 32'd1);
   endtask

   // Monitor: pops the scoreboard on each newly lit digit, checks lit length and frame spacing
   always @(negedge clk) begin
      if ((an != 4'd0) && (prevAn == 4'd0)) begin
         if (sbQ.size() == 0) begin
            checkOutput("sb_unexpected_digit", {24'd0, an, nib}, 32'd0);
         end else begin
            expEnt = sbQ.pop_front();
            checkOutput("sb_digit", {24'd0, an, nib}, {24'd0, expEnt});
         end
         litLen = 1;
      end else if (an != 4'd0) begin
         checkOutput("an_stable", {28'd0, an}, {28'd0, prevAn});
         litLen++;
      end else if ((prevAn != 4'd0) && lenCheck) begin
         checkOutput("lit_len", litLen, DIGIT_CYC);
      end
      if (frame_done) begin
         fdCount++;
         if (fdCheck && (lastFd >= 0)) checkOutput("frame_period", cyc - lastFd, FRAME);
         lastFd = cyc;
      end
      if (!fdCheck) lastFd = -1;
      if (ld_ack) ackCount++;
      prevAn = an;
   end

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      litLen   = 0;
      lastFd   = -1;
      fdCount  = 0;
      ackCount = 0;
      prevAn   = 4'd0;
      lenCheck = 1'b1;
      fdCheck  = 1'b0;
      rst_n    = 1'b1;
      pl       = 1'b0;
      en       = 1'b0;
      din      = 16'd0;

      // Reset values
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_an", {28'd0, an}, 32'd0);
      checkOutput("reset_nib", {28'd0, nib}, 32'd0);
      checkOutput("reset_idx", {30'd0, scan_idx}, 32'd0);
      checkOutput("reset_ack", {31'd0, ld_ack}, 32'd0);
      checkOutput("reset_fd", {31'd0, frame_done}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Direct load while off, then start scanning
      applyStimulus(16'h0132);
      checkOutput("off_load_ack", {31'd0, ld_ack}, 32'd1);
      @(posedge clk); #1;
      checkOutput("off_load_ack_end", {31'd0, ld_ack}, 32'd0);
      checkOutput("off_an", {28'd0, an}, 32'd0);
      repeat (3) pushFrame(16'h0132);
      en      = 1'b1;
      fdCheck = 1'b1;
      @(posedge clk); #1;
      checkOutput("start_blank_an", {28'd0, an}, 32'd0);
      checkOutput("start_blank_nib", {28'd0, nib}, 32'h2);
      repeat (BLANK_CYC) @(posedge clk);
      #1;
      checkOutput("start_show_an", {28'd0, an}, 32'h1);
      waitFrameDone("wait_f1");
      checkOutput("f1_no_ack", {31'd0, ld_ack}, 32'd0);
      waitFrameDone("wait_f2");

      // Mid-frame load is deferred to the frame boundary
      waitShow(2'd1, "wait_f3_idx1");
      applyStimulus(16'hABCD);
      pushFrame(16'hABCD);
      waitFrameDone("wait_f3");
      checkOutput("midframe_ack_at_fd", {31'd0, ld_ack}, 32'd1);

      // Load coincident with the commit edge waits one more frame
      waitShow(2'd1, "wait_f4_idx1");
      applyStimulus(16'hABCD);
      pushFrame(16'hABCD);
      pushFrame(16'h5555);
      ackBase = ackCount;
      waitShow(2'd3, "wait_f4_idx3");
      repeat (DIGIT_CYC - 1) @(posedge clk);
      #1;
      pl  = 1'b1;
      din = 16'h5555;
      @(posedge clk); #1;
      pl  = 1'b0;
      @(negedge clk);
      checkOutput("commit_edge_fd", {31'd0, frame_done}, 32'd1);
      checkOutput("commit_edge_ack", {31'd0, ld_ack}, 32'd1);
      waitFrameDone("wait_f5");
      checkOutput("second_commit_ack", {31'd0, ld_ack}, 32'd1);
      waitFrameDone("wait_f6");
      checkOutput("no_commit_ack", {31'd0, ld_ack}, 32'd0);
      pushDigits(16'h5555, 3);
      @(negedge clk);
      checkOutput("ack_count", ackCount - ackBase, 32'd2);

      // Disable mid-digit, then restart from digit 0 with the same word
      waitShow(2'd2, "wait_f7_idx2");
      lenCheck = 1'b0;
      fdCheck  = 1'b0;
      fdBase   = fdCount;
      @(posedge clk); #1;
      en = 1'b0;
      @(posedge clk); #1;
      checkOutput("disable_an", {28'd0, an}, 32'd0);
      checkOutput("disable_idx", {30'd0, scan_idx}, 32'd0);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("disable_no_fd", fdCount - fdBase, 32'd0);
      checkOutput("disable_an_held", {28'd0, an}, 32'd0);
      lenCheck = 1'b1;
      repeat (2) pushFrame(16'h5555);
      en = 1'b1;
      @(posedge clk); #1;
      checkOutput("restart_blank_an", {28'd0, an}, 32'd0);
      checkOutput("restart_idx", {30'd0, scan_idx}, 32'd0);
      repeat (BLANK_CYC) @(posedge clk);
      #1;
      checkOutput("restart_show", {24'd0, an, nib}, 32'h15);
      fdCheck = 1'b1;
      waitFrameDone("wait_f8");
      waitFrameDone("wait_f9");
      checkOutput("restart_drain", sbQ.size(), 32'd0);

      // Asynchronous reset between clock edges during a lit digit
      pushDigits(16'h5555, 1);
      waitShow(2'd0, "wait_f10_idx0");
      lenCheck = 1'b0;
      fdCheck  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_an", {28'd0, an}, 32'd0);
      checkOutput("async_rst_nib", {28'd0, nib}, 32'd0);
      checkOutput("async_rst_ack", {31'd0, ld_ack}, 32'd0);
      checkOutput("async_rst_idx", {30'd0, scan_idx}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      repeat (2) pushFrame(16'h0000);
      rst_n    = 1'b1;
      lenCheck = 1'b1;
      fdCheck  = 1'b1;
      waitFrameDone("wait_r1");
      waitFrameDone("wait_r2");
      checkOutput("reset_drain", sbQ.size(), 32'd0);

      // Partial and all-zero words exercise leading-zero handling
      pushFrame(16'h0000);
      pushFrame(16'h0032);
      pushFrame(16'h0000);
      applyStimulus(16'h0032);
      waitFrameDone("wait_z1");
      checkOutput("lz_load_ack", {31'd0, ld_ack}, 32'd1);
      applyStimulus(16'h0000);
      waitFrameDone("wait_z2");
      checkOutput("zero_load_ack", {31'd0, ld_ack}, 32'd1);
      waitFrameDone("wait_z3");
      checkOutput("final_drain", sbQ.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
